// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Control FSM for a multicycle RV32 integer core (R/I-ALU, LW, SW, BEQ/BNE, JAL).
// The state register is held in one always_ff. Control outputs are decoded from
// the current state, so enables can follow mem_ready and EQ in the same cycle.
// Every output is forced low while rst_n is low.
// Optional feature: define PERF_COUNT_EN to add the retired-instruction counter
// output instret[CNT_W-1:0], which counts PCWrite pulses.
module multicycle_control_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr,
    input  logic             EQ,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             PCsrc,
    output logic             ALUsrc,
    output logic             illegal,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUctrl,
    output logic [2:0]       state
`ifdef PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b101
    } state_t;

    // Instruction class captured in DECODE and used by the later states.
    typedef enum logic [2:0] {
        C_RALU   = 3'd0,
        C_IALU   = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4,
        C_JAL    = 3'd5
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Maps the opcode to {legal, class}.
    function automatic logic [3:0] decode_op(input logic [6:0] op);
        case (op)
            7'b0110011: decode_op = {1'b1, C_RALU};
            7'b0010011: decode_op = {1'b1, C_IALU};
            7'b0000011: decode_op = {1'b1, C_LOAD};
            7'b0100011: decode_op = {1'b1, C_STORE};
            7'b1100011: decode_op = {1'b1, C_BRANCH};
            7'b1101111: decode_op = {1'b1, C_JAL};
            default:    decode_op = {1'b0, C_RALU};
        endcase
    endfunction

    // Maps funct3 to {supported, ALU operation}. SUB is R-type only (instr[30]).
    function automatic logic [3:0] decode_alu(input logic [2:0] f3,
                                              input logic       is_r,
                                              input logic       b30);
        case (f3)
            3'b000:  decode_alu = {1'b1, (is_r && b30) ? ALU_SUB : ALU_ADD};
            3'b111:  decode_alu = {1'b1, ALU_AND};
            3'b110:  decode_alu = {1'b1, ALU_OR};
            3'b100:  decode_alu = {1'b1, ALU_XOR};
            3'b010:  decode_alu = {1'b1, ALU_SLT};
            default: decode_alu = {1'b0, ALU_ADD};
        endcase
    endfunction

    state_t      r_state;
    cls_t        r_cls;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic        w_b30;
    logic [3:0]  w_dec;
    logic        w_dec_ok;
    cls_t        w_dec_cls;
    logic [3:0]  w_alu;
    logic        w_alu_ok;
    logic [2:0]  w_alu_ctrl;
    logic        w_unused_instr;

    assign w_op       = instr[6:0];
    assign w_f3       = instr[14:12];
    assign w_b30      = instr[30];
    assign w_dec      = decode_op(w_op);
    assign w_dec_ok   = w_dec[3];
    assign w_dec_cls  = cls_t'(w_dec[2:0]);
    assign w_alu      = decode_alu(w_f3, (r_cls == C_RALU), w_b30);
    assign w_alu_ok   = w_alu[3];
    assign w_alu_ctrl = w_alu[2:0];
    // Register numbers, immediates and bits above 31 do not affect control.
    assign w_unused_instr = ^instr;

    // State sequencing. Reset abandons any access in flight and leaves TRAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cls   <= C_RALU;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (w_dec_ok) begin
                        r_cls   <= w_dec_cls;
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    case (r_cls)
                        C_RALU, C_IALU:   r_state <= w_alu_ok ? S_WB : S_TRAP;
                        C_LOAD, C_STORE:  r_state <= S_MEM;
                        C_BRANCH, C_JAL:  r_state <= S_FETCH;
                        default:          r_state <= S_TRAP;
                    endcase
                end
                S_MEM: begin
                    if (!mem_ready) begin
                        r_state <= S_MEM;
                    end else if (r_cls == C_STORE) begin
                        r_state <= S_FETCH;
                    end else if (r_cls == C_LOAD) begin
                        r_state <= S_WB;
                    end else begin
                        r_state <= S_TRAP;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // Control decode from the current state. Everything is low during reset.
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        PCsrc     = 1'b0;
        ALUsrc    = 1'b0;
        illegal   = 1'b0;
        ImmSrc    = 2'b00;
        ResultSrc = 2'b00;
        ALUctrl   = ALU_ADD;
        state     = S_FETCH;
        if (rst_n) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    IRWrite = mem_ready;
                end
                S_DECODE: begin
                    mem_req = 1'b0;
                end
                S_EXEC: begin
                    case (r_cls)
                        C_RALU: begin
                            ALUsrc  = 1'b0;
                            ImmSrc  = 2'b00;
                            ALUctrl = w_alu_ctrl;
                        end
                        C_IALU: begin
                            ALUsrc  = 1'b1;
                            ImmSrc  = 2'b00;
                            ALUctrl = w_alu_ctrl;
                        end
                        C_LOAD: begin
                            ALUsrc  = 1'b1;
                            ImmSrc  = 2'b00;
                            ALUctrl = ALU_ADD;
                        end
                        C_STORE: begin
                            ALUsrc  = 1'b1;
                            ImmSrc  = 2'b01;
                            ALUctrl = ALU_ADD;
                        end
                        C_BRANCH: begin
                            ALUctrl = ALU_SUB;
                            ImmSrc  = 2'b10;
                            PCWrite = 1'b1;
                            case (w_f3)
                                3'b000:  PCsrc = EQ;
                                3'b001:  PCsrc = ~EQ;
                                default: PCsrc = 1'b0;
                            endcase
                        end
                        C_JAL: begin
                            ImmSrc    = 2'b11;
                            PCWrite   = 1'b1;
                            PCsrc     = 1'b1;
                            RegWrite  = 1'b1;
                            ResultSrc = 2'b10;
                        end
                        default: begin
                            ALUctrl = ALU_ADD;
                        end
                    endcase
                end
                S_MEM: begin
                    // The request is held until the memory returns ready.
                    // A store retires on the ready cycle.
                    mem_req  = 1'b1;
                    MemWrite = (r_cls == C_STORE);
                    if ((r_cls == C_STORE) && mem_ready) begin
                        PCWrite = 1'b1;
                        PCsrc   = 1'b0;
                    end else begin
                        PCWrite = 1'b0;
                    end
                end
                S_WB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = (r_cls == C_LOAD) ? 2'b01 : 2'b00;
                    PCWrite   = 1'b1;
                    PCsrc     = 1'b0;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end else begin
            state = S_FETCH;
        end
    end

`ifdef PERF_COUNT_EN
    logic [CNT_W-1:0] r_instret;

    // Retired-instruction count. Each PCWrite pulse is one retirement. The count wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instret <= {CNT_W{1'b0}};
        end else if (PCWrite) begin
            r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_instret <= r_instret;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// For each instruction, the bench works out the expected per-cycle control
// trace from the opcode and funct3 rules. It drives random memory wait
// states and EQ, and compares every output on the falling edge.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                           ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_BAD = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        EQ;
    logic        mem_ready;
    logic        mem_req, MemWrite, IRWrite, PCWrite, RegWrite, PCsrc, ALUsrc, illegal;
    logic [1:0]  ImmSrc, ResultSrc;
    logic [2:0]  ALUctrl, state;
`ifdef PERF_COUNT_EN
    logic [3:0]  instret;
    logic [3:0]  exp_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_control_unit #(.WIDTH(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .PCsrc(PCsrc), .ALUsrc(ALUsrc), .illegal(illegal),
        .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUctrl(ALUctrl), .state(state)
`ifdef PERF_COUNT_EN
        , .instret(instret)
`endif
    );

    // Expected outputs for one cycle. Each *_c bit marks a field that has a defined value in that cycle.
    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, mw, irw, pcw, rw, ill;
        logic       pcsrc_c, pcsrc;
        logic       alusrc_c, alusrc;
        logic       imm_c;  logic [1:0] imm;
        logic       res_c;  logic [1:0] res;
        logic       alu_c;  logic [2:0] alu;
    } exp_t;

    exp_t e;
    int   checks = 0, errors = 0, cyc = 0;
    int   n_pcw = 0, n_rw = 0, n_mw = 0, last_ir = 0, ir_gap = 0;
    logic last_pcsrc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expected record. It also keeps counts of what the DUT did.
    task automatic compare();
        cyc++;
        chk("state",    32'(state),    32'(e.st));
        chk("mem_req",  32'(mem_req),  32'(e.mem_req));
        chk("MemWrite", 32'(MemWrite), 32'(e.mw));
        chk("IRWrite",  32'(IRWrite),  32'(e.irw));
        chk("PCWrite",  32'(PCWrite),  32'(e.pcw));
        chk("RegWrite", 32'(RegWrite), 32'(e.rw));
        chk("illegal",  32'(illegal),  32'(e.ill));
        if (e.pcsrc_c)  chk("PCsrc",     32'(PCsrc),     32'(e.pcsrc));
        if (e.alusrc_c) chk("ALUsrc",    32'(ALUsrc),    32'(e.alusrc));
        if (e.imm_c)    chk("ImmSrc",    32'(ImmSrc),    32'(e.imm));
        if (e.res_c)    chk("ResultSrc", 32'(ResultSrc), 32'(e.res));
        if (e.alu_c)    chk("ALUctrl",   32'(ALUctrl),   32'(e.alu));
`ifdef PERF_COUNT_EN
        if (rst_n) begin
            chk("instret", 32'(instret), 32'(exp_cnt));
            if (e.pcw) exp_cnt = exp_cnt + 4'd1;
        end else begin
            exp_cnt = 4'd0;
        end
`endif
        if (PCWrite === 1'b1) begin
            n_pcw++;
            last_pcsrc = PCsrc;
        end
        if (RegWrite === 1'b1) n_rw++;
        if (MemWrite === 1'b1) n_mw++;
        if (IRWrite === 1'b1) begin
            ir_gap  = cyc - last_ir;
            last_ir = cyc;
        end
    endtask

    task automatic step(input logic rdy, input exp_t x);
        mem_ready = rdy;
        e = x;
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t idle(input logic [2:0] st);
        exp_t x;
        x = '0;
        x.st = st;
        return x;
    endfunction

    function automatic exp_t rst_exp();
        exp_t x;
        x = '0;
        x.pcsrc_c = 1'b1; x.alusrc_c = 1'b1; x.imm_c = 1'b1; x.res_c = 1'b1; x.alu_c = 1'b1;
        return x;
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // ALU operation for each funct3, or -1 when the funct3 is not supported.
    function automatic int alu_of(input logic [2:0] f3, input logic is_r, input logic b30);
        case (f3)
            3'b000:  return (is_r && b30) ? 1 : 0;
            3'b111:  return 2;
            3'b110:  return 3;
            3'b100:  return 4;
            3'b010:  return 5;
            default: return -1;
        endcase
    endfunction

    task automatic reset_cycle();
        rst_n = 1'b0;
        step(1'b1, rst_exp());
        rst_n = 1'b1;
    endtask

    task automatic trap_then_reset(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t x;
            x = idle(ST_TRAP);
            x.ill = 1'b1;
            instr = 32'h002081B3;
            EQ = rnd1();
            step(rnd1(), x);
        end
        reset_cycle();
    endtask

    // Runs one instruction through the DUT and checks every cycle.
    // eqv < 0 gives a random EQ. abort: 0 none, 1 reset on the fetch-ready cycle, 2 reset on the first MEM cycle.
    task automatic do_instr(input logic [31:0] ins, input int eqv, input int fw,
                            input int mw, input int abort);
        exp_t x;
        int   kind;
        int   alu;
        logic [2:0] f3;
        logic eqb;
        instr = ins;
        f3    = ins[14:12];
        eqb   = (eqv < 0) ? rnd1() : 1'(eqv);
        EQ    = eqb;
        for (int i = 0; i <= fw; i++) begin
            if (abort == 1 && i == fw) begin
                reset_cycle();
                return;
            end
            x = idle(ST_FETCH);
            x.mem_req = 1'b1;
            x.irw = (i == fw);
            step(i == fw, x);
        end
        case (ins[6:0])
            7'h33:   kind = K_R;
            7'h13:   kind = K_I;
            7'h03:   kind = K_LD;
            7'h23:   kind = K_ST;
            7'h63:   kind = K_BR;
            7'h6F:   kind = K_JAL;
            default: kind = K_BAD;
        endcase
        step(rnd1(), idle(ST_DECODE));
        if (kind == K_BAD) begin
            trap_then_reset(3);
            return;
        end
        x = idle(ST_EXEC);
        if (kind == K_R || kind == K_I) begin
            alu = alu_of(f3, kind == K_R, ins[30]);
            if (alu < 0) begin
                step(rnd1(), x);
                trap_then_reset(2);
                return;
            end
            x.alusrc_c = 1'b1; x.alusrc = (kind == K_I);
            x.imm_c = 1'b1; x.imm = 2'b00;
            x.alu_c = 1'b1; x.alu = 3'(alu);
            step(rnd1(), x);
            x = idle(ST_WB);
            x.rw = 1'b1; x.res_c = 1'b1; x.res = 2'b00;
            x.pcw = 1'b1; x.pcsrc_c = 1'b1; x.pcsrc = 1'b0;
            step(rnd1(), x);
        end else if (kind == K_LD || kind == K_ST) begin
            x.alusrc_c = 1'b1; x.alusrc = 1'b1;
            x.alu_c = 1'b1; x.alu = 3'd0;
            x.imm_c = 1'b1; x.imm = (kind == K_ST) ? 2'b01 : 2'b00;
            step(rnd1(), x);
            for (int i = 0; i <= mw; i++) begin
                if (abort == 2 && i == 0) begin
                    reset_cycle();
                    return;
                end
                x = idle(ST_MEM);
                x.mem_req = 1'b1;
                x.mw = (kind == K_ST);
                if (kind == K_ST && i == mw) begin
                    x.pcw = 1'b1; x.pcsrc_c = 1'b1; x.pcsrc = 1'b0;
                end
                step(i == mw, x);
            end
            if (kind == K_LD) begin
                x = idle(ST_WB);
                x.rw = 1'b1; x.res_c = 1'b1; x.res = 2'b01;
                x.pcw = 1'b1; x.pcsrc_c = 1'b1; x.pcsrc = 1'b0;
                step(rnd1(), x);
            end
        end else if (kind == K_BR) begin
            x.alu_c = 1'b1; x.alu = 3'd1;
            x.imm_c = 1'b1; x.imm = 2'b10;
            x.pcw = 1'b1; x.pcsrc_c = 1'b1;
            x.pcsrc = (f3 == 3'b000) ? eqb : ((f3 == 3'b001) ? ~eqb : 1'b0);
            step(rnd1(), x);
        end else begin
            x.imm_c = 1'b1; x.imm = 2'b11;
            x.pcw = 1'b1; x.pcsrc_c = 1'b1; x.pcsrc = 1'b1;
            x.rw = 1'b1; x.res_c = 1'b1; x.res = 2'b10;
            step(rnd1(), x);
        end
    endtask

    initial begin
        int p0, r0, m0, k, ab;
        logic [31:0] ins;
`ifdef PERF_COUNT_EN
        exp_cnt = 4'd0;
`endif
        rst_n = 1'b0; instr = 32'h0; EQ = 1'b0; mem_ready = 1'b0; e = rst_exp();
        step(1'b0, rst_exp());
        step(1'b1, rst_exp());
        rst_n = 1'b1;

        // ADD x3,x1,x2 back to back: one PCWrite, one RegWrite, 4 cycles apart.
        p0 = n_pcw; r0 = n_rw;
        do_instr(32'h002081B3, -1, 0, 0, 0);
        chk("add_pcwrite_once", 32'(n_pcw - p0), 32'd1);
        chk("add_regwrite_once", 32'(n_rw - r0), 32'd1);
        do_instr(32'h002081B3, -1, 0, 0, 0);
        chk("add_latency", 32'(ir_gap), 32'd4);

        // LW with 3 wait cycles in MEM: 5 + 3 cycles, no MemWrite.
        m0 = n_mw;
        do_instr(32'h0000A183, -1, 0, 3, 0);
        chk("lw_no_memwrite", 32'(n_mw - m0), 32'd0);
        do_instr(32'h002081B3, -1, 0, 0, 0);
        chk("lw_latency", 32'(ir_gap), 32'd8);

        // BNE with EQ=1 is not taken. With EQ=0 it is taken. Branch takes 3 cycles.
        do_instr(32'h00209463, 1, 0, 0, 0);
        chk("bne_eq1_pcsrc", 32'(last_pcsrc), 32'd0);
        do_instr(32'h00209463, 0, 0, 0, 0);
        chk("bne_eq0_pcsrc", 32'(last_pcsrc), 32'd1);
        do_instr(32'h002081B3, -1, 0, 0, 0);
        chk("branch_latency", 32'(ir_gap), 32'd3);

        // SW with no wait: one MemWrite cycle, store takes 4 cycles.
        m0 = n_mw;
        do_instr(32'h0020A023, -1, 0, 0, 0);
        chk("sw_memwrite_once", 32'(n_mw - m0), 32'd1);
        do_instr(32'h002081B3, -1, 0, 0, 0);
        chk("sw_latency", 32'(ir_gap), 32'd4);

        // SW aborted by reset on the first MEM cycle: nothing is written.
        m0 = n_mw; p0 = n_pcw;
        do_instr(32'h0020A023, -1, 1, 2, 2);
        chk("sw_abort_no_memwrite", 32'(n_mw - m0), 32'd0);
        chk("sw_abort_no_pcwrite", 32'(n_pcw - p0), 32'd0);

        // Illegal opcode: TRAP stays until reset, with no writes.
        p0 = n_pcw; r0 = n_rw; m0 = n_mw;
        do_instr(32'hFFFFFFFF, -1, 0, 0, 0);
        chk("illegal_no_writes", 32'((n_pcw - p0) + (n_rw - r0) + (n_mw - m0)), 32'd0);

        // Unsupported funct3 on an R-type instruction traps from EXEC.
        do_instr(32'h002091B3, -1, 0, 0, 0);
        do_instr(32'h002081B3, -1, 1, 0, 1);

        // Random instruction mix with random wait states, EQ and occasional resets.
        for (int n = 0; n < 250; n++) begin
            ins = $urandom;
            k = $urandom_range(0, 7);
            case (k)
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h03;
                3: ins[6:0] = 7'h23;
                4: ins[6:0] = 7'h63;
                5: ins[6:0] = 7'h6F;
                default: ins[6:0] = ins[6:0];
            endcase
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
            do_instr(ins, -1, $urandom_range(0, 2), $urandom_range(0, 3), ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction word width (>= 32; bits above 31 ignored).
REQ-002 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port instr  input  WIDTH  instruction from the instruction register / memory data.
REQ-006 SHALL have port EQ  input  1  ALU equality flag.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-008 SHALL have ports mem_req, MemWrite, IRWrite, PCWrite, RegWrite, PCsrc, ALUsrc, illegal  output  1  memory request, store enable, IR load, PC load, register-file write, branch/jump target select, immediate-operand select, sticky illegal-opcode flag.
REQ-009 SHALL have ports ImmSrc  output  2 (00 I, 01 S, 10 B, 11 J) and ResultSrc  output  2 (00 ALU, 01 memory, 10 PC+4).
REQ-010 SHALL have port ALUctrl  output  3 (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT).
REQ-011 SHALL have port state  output  3  current FSM state, for debug.

Function
REQ-012 SHALL implement states FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=101; other codes SHALL go to TRAP.
REQ-013 FETCH: mem_req=1; SHALL hold until mem_ready=1, then pulse IRWrite=1 for that cycle and go to DECODE.
REQ-014 DECODE: opcode instr[6:0] in {0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL} SHALL go to EXEC; any other opcode SHALL go to TRAP.
REQ-015 EXEC, R/I-ALU: ALUsrc=0 (R) or 1 (I), ImmSrc=00; next WB.
REQ-016 EXEC, load/store: ALUsrc=1, ALUctrl=ADD, ImmSrc=00 (load) or 01 (store); next MEM.
REQ-017 EXEC, branch: ALUctrl=SUB, ImmSrc=10, PCWrite=1, PCsrc=EQ when funct3=000 (BEQ), !EQ when funct3=001 (BNE), 0 otherwise; next FETCH.
REQ-018 EXEC, JAL: ImmSrc=11, PCWrite=1, PCsrc=1, RegWrite=1, ResultSrc=10; next FETCH.
REQ-019 ALUctrl for R/I-ALU SHALL decode funct3: 000 ADD (SUB if R-type and instr[30]=1), 111 AND, 110 OR, 100 XOR, 010 SLT; other funct3 SHALL go to TRAP from EXEC with no writes.
REQ-020 MEM: mem_req=1, MemWrite=1 for store only; SHALL hold until mem_ready=1; load then goes to WB; store asserts PCWrite=1, PCsrc=0 on the ready cycle and goes to FETCH.
REQ-021 WB: RegWrite=1, ResultSrc=01 (load) or 00 (ALU), PCWrite=1, PCsrc=0; next FETCH.
REQ-022 RegWrite SHALL be asserted regardless of rd; x0 protection belongs to the register file.
REQ-023 TRAP: illegal=1, mem_req/MemWrite/IRWrite/PCWrite/RegWrite=0; SHALL remain until reset.
REQ-024 All write enables SHALL be 0 in any state/cycle not listed above; each write enable SHALL be high for at most one cycle per instruction.
REQ-025 Latency: ALU 4 cycles, load 5, store 4, branch/JAL 3, each plus memory wait cycles.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force state=FETCH and clear illegal; during reset all write enables and mem_req SHALL be 0, other outputs 0.
REQ-027 Reset mid-MEM or mid-FETCH SHALL abandon the access; no write SHALL occur on the reset cycle.

Configuration
REQ-028 Macro PERF_COUNT_EN: when defined, SHALL add output instret [CNT_W-1:0], reset to 0, incremented once per PCWrite pulse, wrapping to 0 on overflow; when undefined the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-029 ADD x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXEC,WB; RegWrite=1 only in WB, ALUctrl=000, PCWrite once.
REQ-030 LW with mem_ready low 3 cycles in MEM -> state holds MEM, mem_req=1 throughout, then WB with ResultSrc=01.
REQ-031 BNE with EQ=1 -> PCsrc=0, PCWrite=1 in EXEC; with EQ=0 -> PCsrc=1.
REQ-032 instr=0xFFFFFFFF -> TRAP after DECODE, illegal=1 sticky, no writes until rst_n=0 returns FETCH.
REQ-033 rst_n=0 during MEM of SW -> MemWrite=0, state=FETCH next cycle; with PERF_COUNT_EN, instret unchanged by aborted store and wraps 0xFFFFFFFF->0.
